// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Supports sequential increment, relative branch, absolute jump, and call/return
// through a circular return-address stack. Also provides stall and sticky error flags.
module pc_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned       INSTR_BYTES  = 4,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             taken,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ovf,
    output logic             unf,
    output logic             misalign
);

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_t;

    localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    // wr_ptr points at the next free slot; the top of the stack sits one below it.
    // Because the depth is a power of two, a push into a full stack wraps around
    // and overwrites the oldest entry.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] raw_pc;
    logic [WIDTH-1:0] next_pc;
    logic             push;
    logic             pop;
    logic             set_unf;
    logic             set_mis;

    assign seq_pc    = pc_out + STEP;
    assign top_idx   = wr_ptr - PTR_W'(1);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_FULL);

    // Decode the operation into the next PC value and the stack/flag actions.
    always_comb begin
        raw_pc  = seq_pc;
        next_pc = seq_pc;
        push    = 1'b0;
        pop     = 1'b0;
        set_unf = 1'b0;
        set_mis = 1'b0;
        case (op)
            OP_BRANCH: begin
                if (taken) begin
                    raw_pc  = pc_out + offset;
                    next_pc = raw_pc & ~ALIGN_MASK;
                    set_mis = |(raw_pc & ALIGN_MASK);
                end
            end
            OP_JUMP: begin
                raw_pc  = target;
                next_pc = raw_pc & ~ALIGN_MASK;
                set_mis = |(raw_pc & ALIGN_MASK);
            end
            OP_CALL: begin
                raw_pc  = target;
                next_pc = raw_pc & ~ALIGN_MASK;
                set_mis = |(raw_pc & ALIGN_MASK);
                push    = 1'b1;
            end
            OP_RET: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    next_pc = ras[top_idx];
                end else begin
                    set_unf = 1'b1;
                end
            end
            default: next_pc = seq_pc;
        endcase
    end

    // Update the PC, stack pointer, occupancy count and sticky flags.
    // Reset takes priority over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out   <= RESET_VECTOR;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            misalign <= 1'b0;
        end else if (!stall) begin
            pc_out <= next_pc;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (count == CNT_FULL) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (pop) begin
                wr_ptr <= top_idx;
                count  <= count - CNT_W'(1);
            end
            if (set_unf) begin
                unf <= 1'b1;
            end
            if (set_mis) begin
                misalign <= 1'b1;
            end
        end
    end

    // Write return addresses into the stack storage.
    // The storage itself needs no reset: the occupancy count guards every read.
    always_ff @(posedge clk) begin
        if (!rst && !stall && push) begin
            ras[wr_ptr] <= seq_pc;
        end
    end

endmodule
